// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the WB stage and a long-latency unit.
// Optional same-cycle long-unit bypass on an idle port is enabled by defining WB_BYPASS_EN.
module wb_port_arbiter #(
    parameter int DATA_W       = 16,
    parameter int RADDR_W      = 3,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_valid,
    input  logic [RADDR_W-1:0]         wb_rd,
    input  logic [DATA_W-1:0]          wb_data,
    output logic                       wb_stall,
    input  logic                       lu_valid,
    input  logic [RADDR_W-1:0]         lu_rd,
    input  logic [DATA_W-1:0]          lu_data,
    output logic                       lu_ready,
    output logic                       rf_we,
    output logic [RADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    logic [RADDR_W-1:0] rd_q   [DEPTH];
    logic [DATA_W-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0]   live_q;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [AGE_W-1:0]   age;

    logic not_empty, head_live, head_dead, starve;
    logic wb_write, head_write, bypass, push, pop;

    always_comb begin
        not_empty  = (count != '0);
        head_live  = not_empty && live_q[rd_ptr];
        head_dead  = not_empty && !live_q[rd_ptr];
        starve     = head_live && (age == AGE_MAX);
        wb_write   = !rst && wb_valid && !starve;
        head_write = !rst && head_live && (starve || !wb_valid);
`ifdef WB_BYPASS_EN
        bypass     = !rst && lu_valid && !not_empty && !wb_valid;
`else
        bypass     = 1'b0;
`endif
        lu_ready   = !rst && (count < FULL);
        push       = lu_valid && lu_ready && !bypass;
        // Dead heads leave without touching the port.
        pop        = head_write || (!rst && head_dead);
        wb_stall   = !rst && starve;
        rf_we      = wb_write || head_write || bypass;
        rf_waddr   = '0;
        rf_wdata   = '0;
        if (head_write) begin
            rf_waddr = rd_q[rd_ptr];
            rf_wdata = data_q[rd_ptr];
        end else if (wb_write) begin
            rf_waddr = wb_rd;
            rf_wdata = wb_data;
        end else if (bypass) begin
            rf_waddr = lu_rd;
            rf_wdata = lu_data;
        end
        fifo_count = count;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            age    <= '0;
            live_q <= '0;
        end else begin
            // Kill older results to the same register; a same-cycle push below wins.
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_write && (rd_q[i] == wb_rd))
                    live_q[i] <= 1'b0;
            end
            if (push) begin
                live_q[wr_ptr] <= 1'b1;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (pop || !head_live)
                age <= '0;
            else if (age != AGE_MAX)
                age <= age + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wr_ptr]   <= lu_rd;
            data_q[wr_ptr] <= lu_data;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter against a queue-based reference model.
module tb_wb_port_arbiter;
    localparam int DATA_W = 16, RADDR_W = 3, DEPTH = 4, STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic rst, wb_valid, wb_stall, lu_valid, lu_ready, rf_we;
    logic [RADDR_W-1:0] wb_rd, lu_rd, rf_waddr;
    logic [DATA_W-1:0] wb_data, lu_data, rf_wdata;
    logic [$clog2(DEPTH):0] fifo_count;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fifo_count(fifo_count));

    typedef struct { logic [RADDR_W-1:0] rd; logic [DATA_W-1:0] data; bit live; } ent_t;
    ent_t q[$];
    int age;
    int total = 0, bad = 0;
    logic s_we, s_stall, s_rdy;
    logic [RADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_data;
    logic [31:0] s_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of stimulus: drive, predict, compare, then advance the model at the edge.
    task automatic step(input bit r, input bit wv, input logic [RADDR_W-1:0] wr, input logic [DATA_W-1:0] wd,
                        input bit lv, input logic [RADDR_W-1:0] lr, input logic [DATA_W-1:0] ld);
        bit e_we = 0, e_stall = 0, e_rdy = 0, do_pop = 0, do_push = 0, do_kill = 0, byp = 0, head_live;
        logic [RADDR_W-1:0] e_a = '0;
        logic [DATA_W-1:0] e_d = '0;
        ent_t ne;
        @(negedge clk);
        rst = r; wb_valid = wv; wb_rd = wr; wb_data = wd; lu_valid = lv; lu_rd = lr; lu_data = ld;
        if (r) begin
            q.delete();
            age = 0;
        end
        head_live = (q.size() > 0) && q[0].live;
        if (!r) begin
            e_rdy = (q.size() < DEPTH);
`ifdef WB_BYPASS_EN
            byp = lv && (q.size() == 0) && !wv;
`endif
            if (head_live && age == STARVE_LIMIT) begin
                e_stall = 1; e_we = 1; e_a = q[0].rd; e_d = q[0].data; do_pop = 1;
            end else if (wv) begin
                e_we = 1; e_a = wr; e_d = wd; do_kill = 1;
            end else if (head_live) begin
                e_we = 1; e_a = q[0].rd; e_d = q[0].data; do_pop = 1;
            end else if (byp) begin
                e_we = 1; e_a = lr; e_d = ld;
            end
            if (q.size() > 0 && !q[0].live) do_pop = 1;
            do_push = lv && e_rdy && !byp;
        end
        #1;
        s_we = rf_we; s_stall = wb_stall; s_rdy = lu_ready; s_addr = rf_waddr; s_data = rf_wdata;
        s_cnt = 32'(fifo_count);
        chk("rf_we", 32'(rf_we), 32'(e_we));
        chk("rf_waddr", 32'(rf_waddr), 32'(e_a));
        chk("rf_wdata", 32'(rf_wdata), 32'(e_d));
        chk("wb_stall", 32'(wb_stall), 32'(e_stall));
        chk("lu_ready", 32'(lu_ready), 32'(e_rdy));
        chk("fifo_count", 32'(fifo_count), 32'(q.size()));
        @(posedge clk);
        if (!r) begin
            if (do_kill)
                foreach (q[i]) if (q[i].rd == wr) q[i].live = 0;
            if (do_pop || !head_live) age = 0;
            else if (age < STARVE_LIMIT) age++;
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                ne.rd = lr; ne.data = ld; ne.live = 1;
                q.push_back(ne);
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; wb_valid = 0; wb_rd = 0; wb_data = 0; lu_valid = 0; lu_rd = 0; lu_data = 0;
        q.delete(); age = 0;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        idle();

        // Priority: WB wins, long-unit result queued then written on the next idle cycle
        step(0, 1, 2, 16'h1234, 1, 5, 16'hBEEF);
        chk("prio_we", 32'(s_we), 1); chk("prio_addr", 32'(s_addr), 2); chk("prio_data", 32'(s_data), 32'h1234);
        idle();
        chk("prio_cnt", s_cnt, 1); chk("prio_q_addr", 32'(s_addr), 5); chk("prio_q_data", 32'(s_data), 32'hBEEF);
        idle();
        chk("prio_empty", s_cnt, 0);

        // Starvation: head waits STARVE_LIMIT cycles, then steals the port for one cycle
        step(0, 1, 0, 16'h0000, 1, 6, 16'h0606);
        for (int i = 0; i < STARVE_LIMIT; i++) begin
            step(0, 1, 7, 16'h7777, 0, 0, 0);
            chk("starve_wait", 32'(s_stall), 0);
        end
        step(0, 1, 7, 16'h7777, 0, 0, 0);
        chk("starve_stall", 32'(s_stall), 1); chk("starve_addr", 32'(s_addr), 6); chk("starve_data", 32'(s_data), 32'h0606);
        step(0, 1, 7, 16'h7777, 0, 0, 0);
        chk("starve_resume", 32'(s_addr), 7); chk("starve_resume_stall", 32'(s_stall), 0);
        idle();

        // Kill: a WB write to the same register cancels the queued result
        step(0, 1, 0, 16'h0000, 1, 3, 16'hAAAA);
        step(0, 1, 3, 16'h5555, 0, 0, 0);
        chk("kill_data", 32'(s_data), 32'h5555);
        idle();
        chk("kill_dead_we", 32'(s_we), 0);
        idle();
        chk("kill_cnt", s_cnt, 0); chk("kill_we", 32'(s_we), 0);

        // Full: four results accepted while WB is busy, fifth is held off
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 16'h0, 1, 3'(i + 1), 16'(16'hC000 + i));
        step(0, 1, 0, 16'h0, 1, 5, 16'hDEAD);
        chk("full_rdy", 32'(s_rdy), 0); chk("full_cnt", s_cnt, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            chk("full_order_addr", 32'(s_addr), 32'(i + 1)); chk("full_order_data", 32'(s_data), 32'hC000 + 32'(i));
        end
        idle();

        // Bypass latency on an idle port
        step(0, 0, 0, 0, 1, 1, 16'h00FF);
`ifdef WB_BYPASS_EN
        chk("bypass_same", 32'(s_we), 1);
        idle();
        chk("bypass_after", 32'(s_we), 0);
`else
        chk("bypass_same", 32'(s_we), 0);
        idle();
        chk("bypass_next", 32'(s_we), 1); chk("bypass_addr", 32'(s_addr), 1); chk("bypass_data", 32'(s_data), 32'h00FF);
`endif
        idle();

        // Reset mid-stream with three queued entries
        for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h0, 1, 3'(i + 4), 16'(i));
        step(1, 1, 1, 16'h1111, 1, 2, 16'h2222);
        chk("rst_we", 32'(s_we), 0); chk("rst_cnt", s_cnt, 0); chk("rst_rdy", 32'(s_rdy), 0);
        step(1, 0, 0, 0, 0, 0, 0);
        idle();
        chk("rst_after_rdy", 32'(s_rdy), 1); chk("rst_after_cnt", s_cnt, 0); chk("rst_after_we", 32'(s_we), 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 99) < 60), 3'($urandom), 16'($urandom),
                 ($urandom_range(0, 99) < 50), 3'($urandom), 16'($urandom));
        end
        step(1, 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
